// File: rtl/panel_pkg.sv
// Shared types and constants for the front-panel input block.
package panel_pkg;

  localparam int DEBOUNCE_DEFAULT = 50000;

  typedef enum logic [1:0] {
    ST_HALT = 2'b00,
    ST_RUN  = 2'b01,
    ST_STEP = 2'b10
  } state_t;

  // Counter only needs to reach DEBOUNCE_CYCLES-1.
  function automatic int cnt_width(input int cycles);
    return (cycles < 2) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/debouncer.sv
// One-bit 2-flop synchronizer followed by a stable-count debouncer.
module debouncer
  import panel_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic db,
  output logic chg
);

  localparam int               CNT_W   = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync <= '0;
      cnt  <= '0;
      db   <= 1'b0;
      chg  <= 1'b0;
    end else begin
      sync <= {sync[0], raw};
      chg  <= 1'b0;
      if (sync[1] != db) begin
        if (cnt == CNT_MAX) begin
          db  <= sync[1];
          cnt <= '0;
          chg <= 1'b1;   // coincides with the new db value
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/panel_switches.sv
// Front-panel switch/button input block: debounce, press edges, HALT/RUN/STEP
// machine control and deposit capture.
module panel_switches
  import panel_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int NUM_SW          = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NUM_SW-1:0] sw_raw,
  input  logic              btn_run,
  input  logic              btn_halt,
  input  logic              btn_step,
  input  logic              btn_deposit,
  input  logic              machine_halt_req,
  output logic [NUM_SW-1:0] sw_value,
  output logic              sw_changed,
  output logic              deposit_pulse,
  output logic [NUM_SW-1:0] deposit_data,
  output logic              run_state,
  output logic              halted,
  output logic              step_pulse
);

  localparam int NUM_IN = NUM_SW + 4;
  localparam int B_RUN  = 0;
  localparam int B_HALT = 1;
  localparam int B_STEP = 2;
  localparam int B_DEP  = 3;

  logic [NUM_IN-1:0] raw_all, db_all, chg_all;
  logic [3:0]        press;
  state_t            state, nxt;

  assign raw_all = {btn_deposit, btn_step, btn_halt, btn_run, sw_raw};

  debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db [NUM_IN-1:0] (
    .clk     (clk),
    .reset_n (reset_n),
    .raw     (raw_all),
    .db      (db_all),
    .chg     (chg_all)
  );

  assign sw_value   = db_all[NUM_SW-1:0];
  assign sw_changed = |chg_all[NUM_SW-1:0];

  // A change that left the button high is a press; releases are dropped.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) press <= '0;
    else          press <= chg_all[NUM_IN-1:NUM_SW] & db_all[NUM_IN-1:NUM_SW];
  end

  always_comb begin
    nxt = state;
    case (state)
      ST_HALT: begin
        if      (press[B_HALT]) nxt = ST_HALT;
        else if (press[B_RUN])  nxt = ST_RUN;
        else if (press[B_STEP]) nxt = ST_STEP;
      end
      ST_RUN:  if (press[B_HALT] || machine_halt_req) nxt = ST_HALT;
      ST_STEP: nxt = ST_HALT;
      default: nxt = ST_HALT;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ST_HALT;
      run_state     <= 1'b0;
      halted        <= 1'b1;
      step_pulse    <= 1'b0;
      deposit_pulse <= 1'b0;
      deposit_data  <= '0;
    end else begin
      state         <= nxt;
      run_state     <= (nxt == ST_RUN);
      halted        <= (nxt == ST_HALT);
      step_pulse    <= (nxt == ST_STEP);
      deposit_pulse <= press[B_DEP] && (state == ST_HALT);
      if (press[B_DEP] && (state == ST_HALT)) deposit_data <= sw_value;
    end
  end

endmodule

// File: tb/tb_panel_switches.sv
// Scoreboard bench for panel_switches: a stable-window reference model queues
// expected output events, a negedge monitor pops and compares them.
module tb_panel_switches;

  localparam int D   = 4;
  localparam int NSW = 8;
  localparam int NIN = NSW + 4;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic [NSW-1:0] sw_raw = '0;
  logic           btn_run = 1'b0, btn_halt = 1'b0, btn_step = 1'b0, btn_deposit = 1'b0;
  logic           machine_halt_req = 1'b0;
  logic [NSW-1:0] sw_value, deposit_data;
  logic           sw_changed, deposit_pulse, run_state, halted, step_pulse;

  panel_switches #(.DEBOUNCE_CYCLES(D), .NUM_SW(NSW)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .sw_raw           (sw_raw),
    .btn_run          (btn_run),
    .btn_halt         (btn_halt),
    .btn_step         (btn_step),
    .btn_deposit      (btn_deposit),
    .machine_halt_req (machine_halt_req),
    .sw_value         (sw_value),
    .sw_changed       (sw_changed),
    .deposit_pulse    (deposit_pulse),
    .deposit_data     (deposit_data),
    .run_state        (run_state),
    .halted           (halted),
    .step_pulse       (step_pulse)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] swv;
    logic       swc;
    logic       dp;
    logic [7:0] dd;
    logic       stp;
    logic       run;
    logic       hlt;
  } snap_t;

  typedef struct {
    int    cyc;
    snap_t s;
  } evt_t;

  typedef enum int {M_HALT, M_RUN, M_STEP} mstate_t;

  evt_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: an input's debounced value flips once the synchronized
  // samples (two cycles old) have disagreed with it for D consecutive cycles.
  initial begin
    logic [NIN-1:0] hist[$];
    logic [NIN-1:0] db_m, chg, raw;
    logic [3:0]     press_m, rose_last;
    logic [7:0]     ddata_m;
    logic           dep, prun, phalt, stable;
    mstate_t        st_m;
    int             cyc_m;
    snap_t          s;
    evt_t           e;
    cyc_m = 0; db_m = '0; press_m = '0; rose_last = '0; ddata_m = '0;
    st_m = M_HALT; prun = 1'b0; phalt = 1'b1;
    for (int k = 0; k < D + 2; k++) hist.push_front('0);
    forever begin
      @(posedge clk);
      cyc_m++;
      if (!reset_n) begin
        hist.push_front('0);
        hist.pop_back();
        db_m = '0; press_m = '0; rose_last = '0; ddata_m = '0;
        st_m = M_HALT; prun = 1'b0; phalt = 1'b1;
      end else begin
        raw = {btn_deposit, btn_step, btn_halt, btn_run, sw_raw};
        hist.push_front(raw);
        hist.pop_back();
        dep = press_m[3] && (st_m == M_HALT);
        if (dep) ddata_m = db_m[7:0];
        case (st_m)
          M_HALT: begin
            if (press_m[1])      st_m = M_HALT;
            else if (press_m[0]) st_m = M_RUN;
            else if (press_m[2]) st_m = M_STEP;
          end
          M_RUN:  if (press_m[1] || machine_halt_req) st_m = M_HALT;
          default: st_m = M_HALT;
        endcase
        press_m = rose_last;
        chg = '0;
        for (int i = 0; i < NIN; i++) begin
          stable = 1'b1;
          for (int k = 2; k < D + 2; k++) if (hist[k][i] == db_m[i]) stable = 1'b0;
          chg[i] = stable;
        end
        db_m      = db_m ^ chg;
        rose_last = chg[NIN-1:NSW] & db_m[NIN-1:NSW];
        s.swv = db_m[7:0];
        s.swc = |chg[7:0];
        s.dp  = dep;
        s.dd  = ddata_m;
        s.stp = (st_m == M_STEP);
        s.run = (st_m == M_RUN);
        s.hlt = (st_m == M_HALT);
        if (s.swc || s.dp || s.stp || (s.run != prun) || (s.hlt != phalt)) begin
          e.cyc = cyc_m;
          e.s   = s;
          q.push_back(e);
        end
        prun  = s.run;
        phalt = s.hlt;
      end
    end
  end

  // Monitor: any pulse or lamp change on the DUT is an event to match.
  initial begin
    int    mcyc;
    logic  prun, phalt;
    snap_t s;
    evt_t  e;
    mcyc = 0; prun = 1'b0; phalt = 1'b1;
    forever begin
      @(negedge clk);
      mcyc++;
      if (!reset_n) begin
        prun = 1'b0; phalt = 1'b1;
      end else begin
        s = '{swv: sw_value, swc: sw_changed, dp: deposit_pulse, dd: deposit_data,
              stp: step_pulse, run: run_state, hlt: halted};
        while (q.size() > 0 && q[0].cyc < mcyc) begin
          n_cmp++; n_bad++;
          $display("FAIL missing_event: cycle %0d expected snapshot %h not seen", q[0].cyc, q[0].s);
          void'(q.pop_front());
        end
        if (s.swc || s.dp || s.stp || (s.run != prun) || (s.hlt != phalt)) begin
          n_cmp++;
          if (q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_event: cycle %0d got snapshot %h, none expected", mcyc, s);
          end else begin
            e = q.pop_front();
            if (e.cyc != mcyc || e.s !== s) begin
              n_bad++;
              $display("FAIL event: got cycle %0d snapshot %h expected cycle %0d snapshot %h",
                       mcyc, s, e.cyc, e.s);
            end
          end
        end
        prun  = s.run;
        phalt = s.hlt;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    #1 reset_n = 1'b0;
    tick(n);
    reset_n = 1'b1;
  endtask

  initial begin
    logic [NIN-1:0] rv;
    int             hold[NIN];
    tick(3);
    reset_n = 1'b1;
    chk("reset_halted",   halted, 1);
    chk("reset_run",      run_state, 0);
    chk("reset_sw_value", sw_value, 0);
    chk("reset_dep_data", deposit_data, 0);
    chk("reset_dep_p",    deposit_pulse, 0);
    chk("reset_step_p",   step_pulse, 0);
    chk("reset_sw_chg",   sw_changed, 0);
    tick(20);

    // bounce then settle high
    sw_raw[3] = 1'b1; tick(1); sw_raw[3] = 1'b0; tick(1);
    sw_raw[3] = 1'b1; tick(1); sw_raw[3] = 1'b0; tick(1);
    sw_raw[3] = 1'b1; tick(10);
    chk("bounce_settled", sw_value, 8'h08);
    for (int g = 1; g <= 3; g++) begin
      sw_raw[5] = 1'b1; tick(g); sw_raw[5] = 1'b0; tick(6);
    end
    chk("glitch_filtered", sw_value, 8'h08);

    // run, then CPU halt request
    btn_run = 1'b1; tick(10); btn_run = 1'b0; tick(4);
    chk("run_after_press", run_state, 1);
    machine_halt_req = 1'b1; tick(1); machine_halt_req = 1'b0;
    chk("halt_req_halted", halted, 1);
    chk("halt_req_run",    run_state, 0);

    // single step in HALT, ignored step in RUN
    btn_step = 1'b1; tick(6); btn_step = 1'b0; tick(6);
    chk("after_step_halted", halted, 1);
    btn_run = 1'b1; tick(8); btn_run = 1'b0; tick(4);
    btn_step = 1'b1; tick(8); btn_step = 1'b0; tick(4);
    chk("step_in_run", run_state, 1);
    btn_halt = 1'b1; tick(8); btn_halt = 1'b0; tick(4);
    chk("halt_press", halted, 1);

    // deposit in HALT captured, in RUN discarded
    sw_raw = 8'hA5; tick(10);
    btn_deposit = 1'b1; tick(8); btn_deposit = 1'b0; tick(4);
    chk("deposit_data", deposit_data, 8'hA5);
    sw_raw = 8'h3C; tick(10);
    btn_run = 1'b1; tick(8); btn_run = 1'b0; tick(4);
    btn_deposit = 1'b1; tick(8); btn_deposit = 1'b0; tick(4);
    chk("deposit_in_run", deposit_data, 8'hA5);
    btn_halt = 1'b1; tick(8); btn_halt = 1'b0; tick(4);

    // halt beats run when pressed together
    btn_run = 1'b1; btn_halt = 1'b1; tick(10); btn_run = 1'b0; btn_halt = 1'b0; tick(6);
    chk("run_halt_together", halted, 1);

    // reset mid-debounce drops the pending press
    btn_run = 1'b1; tick(2);
    @(negedge clk);
    #1 reset_n = 1'b0; btn_run = 1'b0;
    tick(2); reset_n = 1'b1; tick(12);
    chk("reset_mid_debounce", halted, 1);
    btn_run = 1'b1; tick(2); do_reset(2); tick(12);
    chk("held_through_reset", run_state, 1);
    btn_run = 1'b0; tick(2);
    btn_halt = 1'b1; tick(8); btn_halt = 1'b0; tick(4);

    // randomized traffic
    rv = '0;
    for (int i = 0; i < NIN; i++) hold[i] = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NIN; i++) begin
        if (hold[i] == 0) begin
          rv[i]   = 1'($urandom_range(0, 1));
          hold[i] = $urandom_range(1, 10);
        end else begin
          hold[i]--;
        end
      end
      sw_raw           = rv[NSW-1:0];
      btn_run          = rv[NSW];
      btn_halt         = rv[NSW+1] & ($urandom_range(0, 3) == 0);
      btn_step         = rv[NSW+2];
      btn_deposit      = rv[NSW+3];
      machine_halt_req = ($urandom_range(0, 19) == 0);
      if (c == 1500) do_reset(3);
      else tick(1);
    end

    sw_raw = '0; btn_run = 1'b0; btn_halt = 1'b0; btn_step = 1'b0;
    btn_deposit = 1'b0; machine_halt_req = 1'b0;
    tick(30);
    chk("queue_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
